// File: rtl/button_debounce_if.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce_if
//  Description : Bundle of the pushbutton signals exchanged between the
//                debouncer and its surroundings.
//                  button      - raw pad level, asynchronous, may bounce
//                  btn_level   - debounced level, 1 = pressed
//                  btn_press   - one-cycle strobe on an accepted press
//                  btn_release - one-cycle strobe on an accepted release
//                  btn_toggle  - flips on every accepted press
//                Modports:
//                  master - drives the pad, consumes the conditioned outputs
//                  slave  - the debouncer itself
//  Revision    : 1.0 - initial release
// ============================================================================
interface button_debounce_if;
   logic button;
   logic btn_level;
   logic btn_press;
   logic btn_release;
   logic btn_toggle;

   modport master (
      output button,
      input  btn_level,
      input  btn_press,
      input  btn_release,
      input  btn_toggle
   );

   modport slave (
      input  button,
      output btn_level,
      output btn_press,
      output btn_release,
      output btn_toggle
   );
endinterface : button_debounce_if
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : button_debounce
//  Description : Conditions a raw pushbutton pad. The pad is brought into the
//                clk domain by a two-flop synchroniser, then a four-state
//                stability FSM accepts a new level only after it has been
//                seen unchanged for DEBOUNCE_CYCLES consecutive cycles.
//                Produces a clean level, press/release strobes and a
//                press-toggled latch. All outputs are registered.
//
//  Parameters  : DEBOUNCE_CYCLES - stable cycles needed to accept a level
//                                  (2 .. 2^24)
//                CNT_W           - counter width, 2^CNT_W > DEBOUNCE_CYCLES
//
//  Ports       : clk    - system clock, rising edge
//                rst    - asynchronous active-high reset, clears all state
//                btn_io - button_debounce_if.slave
//                           button      (in)  raw pad
//                           btn_level   (out) debounced level
//                           btn_press   (out) accepted 0->1 strobe
//                           btn_release (out) accepted 1->0 strobe
//                           btn_toggle  (out) inverts on every press
//
//  Build macro : BUTTON_ACTIVE_LOW_EN - when defined the pad is treated as
//                active low (idles high); otherwise active high.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
   parameter int unsigned CNT_W           = 24
) (
   input  logic             clk,
   input  logic             rst,
   button_debounce_if.slave btn_io
);

   // The cycle that detects the new level at s2 (and moves into a CHECK
   // state) already counts as the first stable sample, so the counter only
   // has to cover the remaining DEBOUNCE_CYCLES-1 samples. The last of those
   // is reached when the counter holds DEBOUNCE_CYCLES-2, which keeps the
   // acceptance on edge N+1+DEBOUNCE_CYCLES.
   localparam logic [CNT_W-1:0] C_ACCEPT_CNT = CNT_W'(DEBOUNCE_CYCLES - 32'd2);

   typedef enum logic [1:0] {
      ST_STABLE_LO = 2'd0,
      ST_CHECK_HI  = 2'd1,
      ST_STABLE_HI = 2'd2,
      ST_CHECK_LO  = 2'd3
   } state_t;

   logic             pad_in;
   logic             s1_q;
   logic             s2_q;
   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             cnt_done;
   logic             level_q;
   logic             press_q;
   logic             release_q;
   logic             toggle_q;

   // ------------------------------------------------------------------------
   // Pad polarity
   // ------------------------------------------------------------------------
`ifdef BUTTON_ACTIVE_LOW_EN
   assign pad_in = ~btn_io.button;
`else
   assign pad_in = btn_io.button;
`endif

   // ------------------------------------------------------------------------
   // Two-flop synchroniser; only s2_q is consumed downstream.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= pad_in;
         s2_q <= s1_q;
      end
   end

   assign cnt_d    = cnt_q + 1'b1;
   assign cnt_done = (cnt_q == C_ACCEPT_CNT);

   // ------------------------------------------------------------------------
   // Stability FSM with registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_STABLE_LO;
         cnt_q     <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         toggle_q  <= 1'b0;
      end else begin
         // Strobes last exactly one cycle unless re-asserted below.
         press_q   <= 1'b0;
         release_q <= 1'b0;

         case (state_q)
            ST_STABLE_LO: begin
               if (s2_q) begin
                  state_q <= ST_CHECK_HI;
                  cnt_q   <= '0;
               end
            end

            ST_CHECK_HI: begin
               if (!s2_q) begin
                  // Glitch: fall back without touching any output.
                  state_q <= ST_STABLE_LO;
                  cnt_q   <= '0;
               end else if (cnt_done) begin
                  state_q  <= ST_STABLE_HI;
                  cnt_q    <= '0;
                  level_q  <= 1'b1;
                  press_q  <= 1'b1;
                  toggle_q <= ~toggle_q;
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            ST_STABLE_HI: begin
               if (!s2_q) begin
                  state_q <= ST_CHECK_LO;
                  cnt_q   <= '0;
               end
            end

            ST_CHECK_LO: begin
               if (s2_q) begin
                  state_q <= ST_STABLE_HI;
                  cnt_q   <= '0;
               end else if (cnt_done) begin
                  state_q   <= ST_STABLE_LO;
                  cnt_q     <= '0;
                  level_q   <= 1'b0;
                  release_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end

            default: begin
               state_q <= ST_STABLE_LO;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign btn_io.btn_level   = level_q;
   assign btn_io.btn_press   = press_q;
   assign btn_io.btn_release = release_q;
   assign btn_io.btn_toggle  = toggle_q;

endmodule : button_debounce
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_debounce
//  Description : Self-checking bench for button_debounce. A behavioural
//                model tracks the synchronised input history as a run length
//                of samples that disagree with the accepted level and flips
//                the level once that run reaches DEBOUNCE_CYCLES. Directed
//                scenarios are followed by random press/release segments.
//                Honours BUTTON_ACTIVE_LOW_EN for the pad polarity.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debounce;

   localparam int unsigned DEB   = 8;
   localparam int unsigned CNT_W = 4;

`ifdef BUTTON_ACTIVE_LOW_EN
   localparam logic ACT_LOW = 1'b1;
`else
   localparam logic ACT_LOW = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   button_debounce_if bif ();

   button_debounce #(
      .DEBOUNCE_CYCLES (DEB),
      .CNT_W           (CNT_W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .btn_io (bif.slave)
   );

   // Reference model state
   logic pressed;
   logic m_s1, m_s2;
   logic m_level, m_press, m_rel, m_tog;
   int   run;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   int n_press_seen;
   int n_rel_seen;

   task automatic model_reset();
      m_s1    = 1'b0;
      m_s2    = 1'b0;
      m_level = 1'b0;
      m_press = 1'b0;
      m_rel   = 1'b0;
      m_tog   = 1'b0;
      run     = 0;
   endtask

   // One rising edge: decide on the samples seen so far, then shift in
   // the new sample.
   task automatic model_edge();
      if (rst) begin
         model_reset();
      end else begin
         m_press = 1'b0;
         m_rel   = 1'b0;
         if (run >= int'(DEB)) begin
            m_level = ~m_level;
            if (m_level) begin
               m_press = 1'b1;
               m_tog   = ~m_tog;
            end else begin
               m_rel = 1'b1;
            end
            run = 0;
         end
         m_s2 = m_s1;
         m_s1 = pressed;
         if (m_s2 != m_level) run = run + 1;
         else                 run = 0;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("level",   32'(bif.btn_level),   32'(m_level));
      chk("press",   32'(bif.btn_press),   32'(m_press));
      chk("release", 32'(bif.btn_release), 32'(m_rel));
      chk("toggle",  32'(bif.btn_toggle),  32'(m_tog));
   endtask

   // Entered and left at a falling edge.
   task automatic cycle(input logic p);
      pressed    = p;
      bif.button = p ^ ACT_LOW;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      if (bif.btn_press)   n_press_seen++;
      if (bif.btn_release) n_rel_seen++;
      @(negedge clk);
   endtask

   task automatic hold(input logic p, input int n);
      repeat (n) cycle(p);
   endtask

   initial begin
      int   pidx;
      logic tog_seq [3];

      model_reset();
      pressed      = 1'b0;
      bif.button   = ACT_LOW;
      n_press_seen = 0;
      n_rel_seen   = 0;

      // Reset state while reset is applied
      #1;
      check_all();
      @(negedge clk);
      hold(1'b0, 3);
      rst = 1'b0;

      // Idle: no strobes
      hold(1'b0, 20);
      chk("idle_no_press", 32'(n_press_seen), 32'd0);

      // Clean press with explicit latency from the first sampling edge
      pidx = 0;
      for (int i = 1; i <= 15; i++) begin
         cycle(1'b1);
         if (bif.btn_press) pidx = i;
      end
      chk("press_latency", 32'(pidx), 32'(DEB + 2));
      pidx = 0;
      for (int i = 1; i <= 15; i++) begin
         cycle(1'b0);
         if (bif.btn_release) pidx = i;
      end
      chk("release_latency", 32'(pidx), 32'(DEB + 2));

      // Bounce rejection: only the final long high is accepted
      n_press_seen = 0;
      hold(1'b1, 3); hold(1'b0, 2);
      hold(1'b1, 5); hold(1'b0, 2);
      hold(1'b1, 7); hold(1'b0, 2);
      hold(1'b1, 15);
      chk("bounce_one_press", 32'(n_press_seen), 32'd1);
      hold(1'b0, 15);

      // Toggle: three clean pairs
      n_press_seen = 0;
      n_rel_seen   = 0;
      for (int k = 0; k < 3; k++) begin
         hold(1'b1, 12);
         tog_seq[k] = bif.btn_toggle;
         hold(1'b0, 12);
      end
      chk("toggle_1", 32'(tog_seq[0]), 32'd1);
      chk("toggle_2", 32'(tog_seq[1]), 32'd0);
      chk("toggle_3", 32'(tog_seq[2]), 32'd1);
      chk("toggle_presses",  32'(n_press_seen), 32'd3);
      chk("toggle_releases", 32'(n_rel_seen),   32'd3);

      // Random segments, some shorter than the debounce window
      for (int k = 0; k < 40; k++) begin
         hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
      end
      hold(1'b0, 12);

      // Asynchronous reset mid-cycle while pressed: outputs clear at once
      hold(1'b1, 12);
      chk("pressed_before_rst", 32'(bif.btn_level), 32'd1);
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      check_all();
      @(negedge clk);
      hold(1'b1, 2);
      rst = 1'b0;
      // Button held through reset yields a fresh press
      n_press_seen = 0;
      hold(1'b1, 12);
      chk("held_through_rst", 32'(n_press_seen), 32'd1);
      hold(1'b0, 12);

      // Reset in the middle of a check: no strobe, then a normal press
      n_press_seen = 0;
      hold(1'b1, 4);
      rst = 1'b1;
      hold(1'b1, 1);
      chk("midcheck_no_press", 32'(n_press_seen), 32'd0);
      rst = 1'b0;
      pidx = 0;
      for (int i = 1; i <= 12; i++) begin
         cycle(1'b1);
         if (bif.btn_press) pidx = i;
      end
      chk("midcheck_latency", 32'(pidx), 32'(DEB + 2));
      hold(1'b0, 12);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_button_debounce
`default_nettype wire
